// File: rtl/hit_detector.sv
// Issuing end of the hit/tank_reset handshake: per-frame projectile/target overlap counting,
// one-cycle hit pulse, burst/tank_reset response tracking and a saturating hit score.
`timescale 1ns/1ps
module hit_detector #(
  parameter int unsigned V_ACTIVE        = 768,
  parameter int unsigned H_ACTIVE        = 1024,
  parameter int unsigned MIN_OVERLAP     = 16,
  parameter logic [31:0] BURST_TIMEOUT   = 32'd1000,
  parameter int unsigned COOLDOWN_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pixel_column,
  input  logic [11:0] pixel_row,
  input  logic [1:0]  target_icon,
  input  logic [1:0]  shot_icon,
  input  logic        enable,
  input  logic        burst,
  input  logic        tank_reset,
  output logic        hit,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  hit_count
);

  localparam logic [11:0] V_LIM   = 12'(V_ACTIVE);
  localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
  localparam logic [15:0] THRESH  = 16'(MIN_OVERLAP);
  localparam logic [7:0]  CD_LAST = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [31:0] TO_LAST = BURST_TIMEOUT - 32'd1;

  typedef enum logic [2:0] {
    IDLE, ARMED, HIT, WAIT_BURST, WAIT_RESET, COOLDOWN
  } state_t;

  state_t      state, state_n;
  logic        row_end, row_end_q, frame_tick;
  logic        ovl_pix, qualify;
  logic [15:0] ovl_cnt, ovl_sum;
  logic        tr_q, tr_rise;
  logic [31:0] timer;
  logic [7:0]  cd_cnt;
  logic        timeout_fire, count_inc;

  // frame_tick is the first cycle the scan sits on the end-of-frame row
  assign row_end    = (pixel_row == V_LIM);
  assign frame_tick = row_end & ~row_end_q;

  assign ovl_pix = (pixel_column < H_LIM) && (pixel_row < V_LIM) &&
                   (|target_icon) && (|shot_icon);
  // Evaluation sees the pixel of the closing cycle as part of that frame
  assign ovl_sum = (ovl_cnt == 16'hFFFF) ? ovl_cnt : ovl_cnt + 16'(ovl_pix);
  assign qualify = (ovl_sum >= THRESH);

  assign tr_rise = tank_reset & ~tr_q;
  assign busy    = !((state == IDLE) || (state == ARMED));

  always_comb begin
    state_n      = state;
    timeout_fire = 1'b0;
    count_inc    = 1'b0;
    case (state)
      IDLE:       if (enable) state_n = ARMED;
      ARMED:      if (frame_tick && qualify) state_n = HIT;
      HIT:        state_n = WAIT_BURST;
      WAIT_BURST: begin
        if (burst) state_n = WAIT_RESET;
        else if (timer >= TO_LAST) begin
          state_n      = ARMED;
          timeout_fire = 1'b1;
        end
      end
      WAIT_RESET: begin
        if (tr_rise) begin
          state_n   = COOLDOWN;
          count_inc = 1'b1;
        end
      end
      COOLDOWN:   if (frame_tick && (cd_cnt == CD_LAST)) state_n = ARMED;
      default:    state_n = IDLE;
    endcase
    if (!enable) begin
      state_n      = IDLE;
      timeout_fire = 1'b0;
      count_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      row_end_q   <= 1'b0;
      tr_q        <= 1'b0;
      ovl_cnt     <= '0;
      timer       <= '0;
      cd_cnt      <= '0;
      hit         <= 1'b0;
      timeout_err <= 1'b0;
      hit_count   <= '0;
    end else begin
      state     <= state_n;
      row_end_q <= row_end;
      tr_q      <= tank_reset;
      hit       <= (state_n == HIT);

      if (!enable || frame_tick) ovl_cnt <= '0;
      else                       ovl_cnt <= ovl_sum;

      // Timer only runs while waiting for burst; any other state clears it
      if (state == WAIT_BURST) timer <= timer + 32'd1;
      else                     timer <= '0;

      if (state != COOLDOWN)  cd_cnt <= '0;
      else if (frame_tick)    cd_cnt <= cd_cnt + 8'd1;

      if (timeout_fire) timeout_err <= 1'b1;
      if (count_inc && (hit_count != 8'hFF)) hit_count <= hit_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// Scoreboard bench for hit_detector: expected hit/score values are queued at stimulus time
// and popped when the DUT output is sampled.
`timescale 1ns/1ps
module tb_hit_detector;

  localparam logic [11:0] VA = 12'd768;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pixel_column = '0;
  logic [11:0] pixel_row = 12'd5;
  logic [1:0]  target_icon = '0;
  logic [1:0]  shot_icon = '0;
  logic        enable = 1'b0;
  logic        burst = 1'b0;
  logic        tank_reset = 1'b0;
  logic        hit, busy, timeout_err;
  logic [7:0]  hit_count;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       hit_q[$];
  logic [7:0] cnt_q[$];

  always #5 clk = ~clk;

  hit_detector #(
    .MIN_OVERLAP(4), .BURST_TIMEOUT(32'd50), .COOLDOWN_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .pixel_column(pixel_column), .pixel_row(pixel_row),
    .target_icon(target_icon), .shot_icon(shot_icon), .enable(enable), .burst(burst),
    .tank_reset(tank_reset), .hit(hit), .busy(busy), .timeout_err(timeout_err),
    .hit_count(hit_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // npix overlap cycles at (col,row), then end-of-frame row; hit is sampled the cycle after tick
  task automatic frame(input int npix, input logic [11:0] col, input logic [11:0] row,
                       input logic exp_hit);
    logic e;
    hit_q.push_back(exp_hit);
    for (int i = 0; i < npix; i++) begin
      pixel_column = col; pixel_row = row; target_icon = 2'd1; shot_icon = 2'd2;
      step();
    end
    target_icon = '0; shot_icon = '0; pixel_column = '0; pixel_row = 12'd5;
    step();
    pixel_row = VA;
    step();
    e = hit_q.pop_front();
    n_checks++;
    if (hit !== e) begin
      n_fail++;
      $display("FAIL frame_hit: hit=%b expected %b (npix=%0d col=%0d row=%0d)",
               hit, e, npix, col, row);
    end
    pixel_row = 12'd5;
  endtask

  task automatic check_count(input string name);
    logic [7:0] e;
    e = cnt_q.pop_front();
    n_checks++;
    if (hit_count !== e) begin
      n_fail++;
      $display("FAIL %s: hit_count=%0d expected %0d", name, hit_count, e);
    end
  endtask

  // Fast full handshake from ARMED back to ARMED
  task automatic handshake();
    frame(4, 12'd10, 12'd10, 1'b1);
    step();
    burst = 1'b1;
    step();
    tank_reset = 1'b1;
    step();
    exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    cnt_q.push_back(exp_cnt);
    tank_reset = 1'b0; burst = 1'b0;
    check_count("handshake_count");
    frame(0, 12'd0, 12'd0, 1'b0);
    frame(0, 12'd0, 12'd0, 1'b0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_rearm: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    step(); step();
    n_checks++;
    if ({hit, busy, timeout_err, hit_count} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: hit=%b busy=%b terr=%b cnt=%0d expected all 0",
               hit, busy, timeout_err, hit_count);
    end
    @(negedge clk) reset = 1'b1;
    enable = 1'b1;
    step();
  endtask

  task automatic test_threshold();
    frame(3, 12'd100, 12'd200, 1'b0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL below_threshold_busy: busy=%b expected 0", busy);
    end
    frame(4, 12'd100, 12'd200, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_busy: busy=%b expected 1", busy);
    end
    step();
    n_checks++;
    if (hit !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_one_cycle: hit=%b expected 0", hit);
    end
  endtask

  // Enters in WAIT_BURST one cycle after the hit
  task automatic test_handshake();
    repeat (4) step();
    burst = 1'b1;
    repeat (95) step();
    n_checks++;
    if (busy !== 1'b1 || hit_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wait_reset_hold: busy=%b cnt=%0d expected 1/0", busy, hit_count);
    end
    tank_reset = 1'b1;
    step();
    exp_cnt = 8'd1;
    cnt_q.push_back(exp_cnt);
    tank_reset = 1'b0; burst = 1'b0;
    check_count("tank_reset_count");
    frame(6, 12'd10, 12'd10, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cooldown_busy: busy=%b expected 1", busy);
    end
    frame(6, 12'd10, 12'd10, 1'b0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cooldown_rearm: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    int k;
    frame(4, 12'd10, 12'd10, 1'b1);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pre: timeout_err=%b expected 0", timeout_err);
    end
    // HIT cycle, then 50 WAIT_BURST cycles, then ARMED
    k = 0;
    while (k < 200) begin
      step();
      k++;
      if (busy === 1'b0) break;
    end
    n_checks++;
    if (k != 51) begin
      n_fail++;
      $display("FAIL timeout_latency: cycles=%0d expected 51", k);
    end
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: timeout_err=%b expected 1", timeout_err);
    end
    cnt_q.push_back(exp_cnt);
    check_count("timeout_count");
  endtask

  task automatic test_saturate();
    while (exp_cnt != 8'hFF) handshake();
    handshake();
  endtask

  task automatic test_reset_mid();
    frame(4, 12'd10, 12'd10, 1'b1);
    step();
    burst = 1'b1;
    step();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({hit, busy, timeout_err, hit_count} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset: hit=%b busy=%b terr=%b cnt=%0d expected all 0",
               hit, busy, timeout_err, hit_count);
    end
    burst = 1'b0;
    @(negedge clk) reset = 1'b1;
    exp_cnt = 8'd0;
    step();
    handshake();
    frame(4, 12'd10, 12'd10, 1'b1);
    step();
    enable = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_drop_idle: busy=%b expected 0", busy);
    end
    cnt_q.push_back(exp_cnt);
    check_count("enable_drop_count");
    enable = 1'b1;
    step();
  endtask

  task automatic test_bounds();
    frame(8, 12'd1030, 12'd10, 1'b0);
    frame(8, 12'd10, 12'd770, 1'b0);
    frame(4, 12'd1023, 12'd767, 1'b1);
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_handshake();
    test_timeout();
    test_saturate();
    test_reset_mid();
    test_bounds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
